clock_enable_manager: RTL and testbench

- Runs on the PLL main clock (150 MHz fabric clock).
- Gates system reset on a stable PLL lock and recovers from lock loss.
- Generates NUM_CH phase-aligned, runtime-programmable clock-enable pulses, replacing fixed extra PLL outputs for slow domains such as the panel shift clock.
- Sits directly after the PLL wrapper; every downstream block takes its reset and enables from here.

---
 rtl/clock_enable_manager.sv | 83 ++++++++
 tb/tb_clock_enable_manager.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_enable_manager.sv
// clock_enable_manager: lock-qualified reset release plus phase-aligned, glitch-free reprogrammable clock-enable channels
module clock_enable_manager #(
  parameter int NUM_CH = 2,
  parameter int DIV_W = 8,
  parameter logic [NUM_CH*DIV_W-1:0] DIV_INIT = {NUM_CH{8'd4}},
  parameter int LOCK_STABLE = 1024,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W = 8,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pll_locked,
  input  logic              div_load,
  input  logic [CH_W-1:0]   div_ch,
  input  logic [DIV_W-1:0]  div_value,
  output logic [NUM_CH-1:0] ce,
  output logic              sys_reset,
  output logic              running,
  output logic [CNT_W-1:0]  lock_lost_count
);
  localparam int SW = $clog2(LOCK_STABLE);
  typedef enum logic [1:0] {WAIT_LOCK, STABILIZE, RUN} state_e;
  state_e state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic lock_s, in_run, enter_run;
  logic [SW-1:0] stab_q, stab_d;
  logic [NUM_CH-1:0][DIV_W-1:0] shadow_q, shadow_d, active_q, active_d, cnt_q, cnt_d;
  logic [NUM_CH-1:0] ce_d;
  logic [CNT_W-1:0] lost_d;
  assign lock_s = sync_q[SYNC_STAGES-1];
  always_comb begin
    state_d = state_q;
    stab_d = '0;
    case (state_q)
      WAIT_LOCK: state_d = lock_s ? STABILIZE : WAIT_LOCK;
      STABILIZE:
        if (!lock_s) state_d = WAIT_LOCK;
        else if (stab_q == SW'(LOCK_STABLE - 1)) state_d = RUN;
        else stab_d = stab_q + 1'b1;
      RUN: state_d = lock_s ? RUN : WAIT_LOCK;
      default: state_d = WAIT_LOCK;
    endcase
  end
  assign in_run = state_d == RUN;
  assign enter_run = in_run && state_q != RUN;
  assign lost_d = (state_q == RUN && !lock_s && lock_lost_count != '1) ? lock_lost_count + 1'b1 : lock_lost_count;
  // ce is high exactly on a channel's wrap cycle, so it doubles as the shadow-to-active strobe
  always_comb begin
    shadow_d = shadow_q;
    if (div_load && int'(div_ch) < NUM_CH) shadow_d[div_ch] = div_value;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = (!in_run || enter_run || ce[i]) ? '0 : cnt_q[i] + 1'b1;
      active_d[i] = (state_q != RUN || ce[i]) ? shadow_q[i] : active_q[i];
      ce_d[i] = in_run && (active_d[i] <= DIV_W'(1) || cnt_d[i] == active_d[i] - 1'b1);
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= WAIT_LOCK;
      sync_q <= '0;
      stab_q <= '0;
      shadow_q <= DIV_INIT;
      active_q <= DIV_INIT;
      cnt_q <= '0;
      ce <= '0;
      sys_reset <= 1'b1;
      running <= 1'b0;
      lock_lost_count <= '0;
    end else begin
      state_q <= state_d;
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
      stab_q <= stab_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      cnt_q <= cnt_d;
      ce <= ce_d;
      sys_reset <= !in_run;
      running <= in_run;
      lock_lost_count <= lost_d;
    end
  end
endmodule

// File: tb/tb_clock_enable_manager.sv
// tb_clock_enable_manager: randomized and directed checks against a schedule-based reference model
module tb_clock_enable_manager;
  localparam int NUM_CH = 3, LS = 16, SS = 2;
  localparam logic [23:0] DIV_INIT = {8'd7, 8'd15, 8'd4};
  logic clock = 0, reset = 1, pll_locked = 0, div_load = 0;
  logic [1:0] div_ch = 0;
  logic [7:0] div_value = 0;
  logic [2:0] ce;
  logic sys_reset, running;
  logic [7:0] lock_lost_count;
  int errors = 0, checks = 0;
  always #5 clock = ~clock;
  clock_enable_manager #(.NUM_CH(NUM_CH), .DIV_W(8), .DIV_INIT(DIV_INIT), .LOCK_STABLE(LS),
    .SYNC_STAGES(SS), .CNT_W(8)) dut (.clock(clock), .reset(reset), .pll_locked(pll_locked),
    .div_load(div_load), .div_ch(div_ch), .div_value(div_value), .ce(ce), .sys_reset(sys_reset),
    .running(running), .lock_lost_count(lock_lost_count));
  // Reference: running after an edge iff the delayed lock has been high for LS+1 edges in a row;
  // each channel fires at a scheduled run cycle, re-reading its shadow ratio after every pulse.
  bit lq[$];
  int streak, mk, sh[NUM_CH], dv[NUM_CH], nxt[NUM_CH];
  bit m_run;
  bit [2:0] m_ce;
  bit [7:0] m_lost;
  logic [12:0] got_v, exp_v;
  assign got_v = {ce, sys_reset, running, lock_lost_count};
  assign exp_v = {m_ce, ~m_run, m_run, m_lost};
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      lq = {};
      for (int i = 0; i < SS; i++) lq.push_back(1'b0);
      streak = 0; mk = 0; m_run = 0; m_ce = '0; m_lost = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        sh[i] = int'(DIV_INIT[i*8 +: 8]); dv[i] = sh[i]; nxt[i] = 0;
      end
    end else begin
      bit ls, nr;
      bit [2:0] nce;
      ls = lq.pop_front();
      lq.push_back(pll_locked);
      streak = ls ? streak + 1 : 0;
      nr = streak > LS;
      if (m_run && !nr && m_lost != 8'hFF) m_lost++;
      mk = nr ? mk + 1 : 0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (!nr || mk == 1 || m_ce[i]) begin
          dv[i] = sh[i];
          nxt[i] = (mk == 1) ? dv[i] : mk - 1 + dv[i];
        end
        nce[i] = nr && (dv[i] <= 1 || mk == nxt[i]);
      end
      m_ce = nce;
      m_run = nr;
      if (div_load && int'(div_ch) < NUM_CH) sh[div_ch] = int'(div_value);
    end
  end
  task automatic start();
    reset = 1; pll_locked = 1; div_load = 0; div_ch = 0;
    @(negedge clock); @(negedge clock);
    reset = 0;
  endtask
  task automatic wait_run(output int n);
    n = 0;
    do begin @(negedge clock); n++; end while (!running && n < 80);
    if (!running) begin errors++; $display("FAIL wait_run timeout running=%b expected 1", running); end
    checks++;
  endtask
  task automatic test_reset();
    int n;
    reset = 1; pll_locked = 1;
    @(negedge clock); @(negedge clock);
    if (got_v !== {3'b000, 1'b1, 1'b0, 8'd0}) begin errors++; $display("FAIL reset_vals got=%h exp=%h", got_v, {3'b000, 1'b1, 1'b0, 8'd0}); end
    checks++;
    reset = 0;
    for (n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (got_v !== exp_v) begin errors++; $display("FAIL model_reset n=%0d got=%h exp=%h", n, got_v, exp_v); end
      checks++;
      if (running) break;
    end
    if (n !== 19) begin errors++; $display("FAIL release_cycle got=%0d exp=19", n); end
    checks++;
    if (sys_reset !== 1'b0) begin errors++; $display("FAIL release_sysreset got=%b exp=0", sys_reset); end
    checks++;
  endtask
  task automatic test_lock_glitch();
    int n;
    start();
    for (n = 1; n <= 60; n++) begin
      @(negedge clock);
      if (got_v !== exp_v) begin errors++; $display("FAIL model_glitch n=%0d got=%h exp=%h", n, got_v, exp_v); end
      checks++;
      if (n == 13) pll_locked = 0;
      if (n == 16) pll_locked = 1;
      if (running) break;
    end
    if (n !== 35) begin errors++; $display("FAIL glitch_release got=%0d exp=35", n); end
    checks++;
    if (lock_lost_count !== 8'd0) begin errors++; $display("FAIL glitch_lost got=%0d exp=0", lock_lost_count); end
    checks++;
  endtask
  task automatic test_divide();
    int n, both = 0;
    start();
    wait_run(n);
    for (int k = 1; k <= 130; k++) begin
      if (got_v !== exp_v) begin errors++; $display("FAIL model_div k=%0d got=%h exp=%h", k, got_v, exp_v); end
      checks++;
      if (ce !== {k % 7 == 0, k % 15 == 0, k % 4 == 0}) begin
        errors++; $display("FAIL div_pattern k=%0d got=%b exp=%b", k, ce, {k % 7 == 0, k % 15 == 0, k % 4 == 0});
      end
      checks++;
      if (ce[0] && ce[1]) both++;
      @(negedge clock);
    end
    if (both !== 2) begin errors++; $display("FAIL div_coincident got=%0d exp=2", both); end
    checks++;
  endtask
  task automatic test_reload();
    int n;
    bit e0;
    start();
    wait_run(n);
    for (int k = 1; k <= 32; k++) begin
      if (got_v !== exp_v) begin errors++; $display("FAIL model_reload k=%0d got=%h exp=%h", k, got_v, exp_v); end
      checks++;
      e0 = k inside {4, 10, 16, 21, 26, 31};
      if (ce !== {k % 7 == 0, k % 15 == 0, e0}) begin
        errors++; $display("FAIL reload_pattern k=%0d got=%b exp=%b", k, ce, {k % 7 == 0, k % 15 == 0, e0});
      end
      checks++;
      div_load = k inside {2, 3, 10, 12};
      div_ch = (k == 3) ? 2'd3 : 2'd0;
      div_value = (k == 2) ? 8'd6 : (k == 3) ? 8'd9 : (k == 10) ? 8'd3 : 8'd5;
      @(negedge clock);
    end
    div_load = 0;
    for (int k = 0; k < 200; k++) begin
      div_load = ($urandom_range(0, 9) == 0);
      div_ch = 2'($urandom_range(0, 3));
      div_value = 8'($urandom_range(0, 12));
      if ($urandom_range(0, 60) == 0) pll_locked = ~pll_locked;
      @(negedge clock);
      if (got_v !== exp_v) begin errors++; $display("FAIL model_random k=%0d got=%h exp=%h", k, got_v, exp_v); end
      checks++;
    end
    div_load = 0; pll_locked = 1;
  endtask
  task automatic test_lock_loss();
    int n, t;
    bit [7:0] ec;
    start();
    div_load = 1; div_ch = 0; div_value = 8'd1;
    @(negedge clock);
    div_load = 0;
    wait_run(n);
    for (int ev = 1; ev <= 300; ev++) begin
      if (ce[0] !== 1'b1) begin errors++; $display("FAIL loss_shadow ev=%0d got=%b exp=1", ev, ce[0]); end
      checks++;
      pll_locked = 0;
      @(negedge clock);
      pll_locked = 1;
      for (t = 0; t < 6 && running; t++) @(negedge clock);
      ec = (ev > 255) ? 8'd255 : 8'(ev);
      if (got_v !== {3'b000, 1'b1, 1'b0, ec}) begin
        errors++; $display("FAIL loss_event ev=%0d got=%h exp=%h", ev, got_v, {3'b000, 1'b1, 1'b0, ec});
      end
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL model_loss ev=%0d got=%h exp=%h", ev, got_v, exp_v); end
      checks++;
      wait_run(n);
    end
    if (lock_lost_count !== 8'd255) begin errors++; $display("FAIL loss_saturate got=%0d exp=255", lock_lost_count); end
    checks++;
  endtask
  task automatic test_d01();
    int n;
    start();
    div_load = 1; div_ch = 1; div_value = 8'd1;
    for (n = 0; n < 40 && !running; n++) begin
      @(negedge clock);
      div_load = 0;
      if (ce[1] !== running) begin errors++; $display("FAIL d1_outside n=%0d got=%b exp=%b", n, ce[1], running); end
      checks++;
    end
    for (int k = 1; k <= 40; k++) begin
      if (ce[1] !== 1'b1) begin errors++; $display("FAIL d01_high k=%0d got=%b exp=1", k, ce[1]); end
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL model_d01 k=%0d got=%h exp=%h", k, got_v, exp_v); end
      checks++;
      div_load = (k == 5); div_ch = 1; div_value = 8'd0;
      @(negedge clock);
    end
    div_load = 0;
    @(posedge clock);
    #2 reset = 1;
    #1;
    if (got_v !== {3'b000, 1'b1, 1'b0, 8'd0}) begin errors++; $display("FAIL async_reset got=%h exp=%h", got_v, {3'b000, 1'b1, 1'b0, 8'd0}); end
    checks++;
    @(negedge clock);
    reset = 0;
    wait_run(n);
    for (int k = 1; k <= 15; k++) begin
      if (ce[1] !== (k == 15)) begin errors++; $display("FAIL div_init_restore k=%0d got=%b exp=%b", k, ce[1], k == 15); end
      checks++;
      @(negedge clock);
    end
  endtask
  initial begin
    test_reset();
    test_lock_glitch();
    test_divide();
    test_reload();
    test_lock_loss();
    test_d01();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
